// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: programmable VGA timing generator with a pixel output stage.
// The fetch counters (hc_out/vc_out) run undelayed. The sync and blank timing derived
// from them passes through a PIPE-stage delay line and then an output register, so
// colour returned by a fixed-latency graphics fetch lines up with hsync/vsync at the pins.
// Ports:
//   vgaclk, rst        clock and synchronous active-high reset
//   pix_en             pixel tick; all state advances only on enabled edges
//   input_red/green/blue  RGB332 colour for the coordinate issued PIPE ticks earlier
//   hc_out, vc_out     fetch column/line counters
//   line_start         high while hc_out==0 (combinational)
//   frame_start        high while hc_out==0 && vc_out==0 (combinational)
//   active, hsync, vsync, red/green/blue  registered pin outputs, PIPE+1 ticks of latency
module vga_timing_pipe #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned PIPE     = 2
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic [2:0]       input_red,
  input  logic [2:0]       input_green,
  input  logic [1:0]       input_blue,
  output logic [CNT_W-1:0] hc_out,
  output logic [CNT_W-1:0] vc_out,
  output logic             line_start,
  output logic             frame_start,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Timing bundle bit positions
  localparam int unsigned T_DE = 2;
  localparam int unsigned T_HS = 1;
  localparam int unsigned T_VS = 0;

  // Elaboration-time parameter sanity
  if (H_TOT > 2**CNT_W || V_TOT > 2**CNT_W) begin : g_bad_cnt_w
    $error("vga_timing_pipe: H or V total exceeds 2**CNT_W");
  end
  if (PIPE > 8) begin : g_bad_pipe
    $error("vga_timing_pipe: PIPE must be 0..8");
  end

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic [31:0]      hc_w;
  logic [31:0]      vc_w;
  logic [2:0]       raw;
  logic [2:0]       tap;

  // Fetch counters: column wraps at H_TOT, line advances on column wrap
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == CNT_W'(H_TOT - 1)) begin
        hc <= '0;
        vc <= (vc == CNT_W'(V_TOT - 1)) ? '0 : vc + CNT_W'(1);
      end else begin
        hc <= hc + CNT_W'(1);
      end
    end
  end

  assign hc_out      = hc;
  assign vc_out      = vc;
  assign line_start  = (hc == '0);
  assign frame_start = (hc == '0) && (vc == '0);

  // Raw timing, compared at 32 bits so window edges equal to 2**CNT_W stay exact
  assign hc_w = 32'(hc);
  assign vc_w = 32'(vc);
  always_comb begin
    raw       = '0;
    raw[T_DE] = (hc_w < H_ACTIVE) && (vc_w < V_ACTIVE);
    raw[T_HS] = (hc_w >= HS_START) && (hc_w < HS_END);
    raw[T_VS] = (vc_w >= VS_START) && (vc_w < VS_END);
  end

  // Delay line matching the graphics fetch latency; cleared stages read as blank/sync-inactive
  if (PIPE == 0) begin : g_no_dly
    assign tap = raw;
  end else begin : g_dly
    logic [2:0] dly [PIPE];
    always_ff @(posedge vgaclk) begin
      if (rst) begin
        for (int i = 0; i < int'(PIPE); i++) dly[i] <= '0;
      end else if (pix_en) begin
        dly[0] <= raw;
        for (int i = 1; i < int'(PIPE); i++) dly[i] <= dly[i-1];
      end
    end
    assign tap = dly[PIPE-1];
  end

  // Pin register; colour forced to black outside the active area, MSB-replicated to 4 bits
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hsync  <= ~HS_POL;
      vsync  <= ~VS_POL;
      active <= 1'b0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else if (pix_en) begin
      hsync  <= tap[T_HS] ? HS_POL : ~HS_POL;
      vsync  <= tap[T_VS] ? VS_POL : ~VS_POL;
      active <= tap[T_DE];
      red    <= tap[T_DE] ? {input_red, input_red[2]}     : 4'h0;
      green  <= tap[T_DE] ? {input_green, input_green[2]} : 4'h0;
      blue   <= tap[T_DE] ? {input_blue, input_blue}      : 4'h0;
    end
  end

endmodule
